// File: rtl/hzd_pkg.sv
// Shared encodings for the GRF hazard controller:
// bypass selects, Tuse/Tnew constants and a Tnew aging helper.
package hzd_pkg;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_W   = 2'd1,
    FWD_M   = 2'd2,
    FWD_E   = 2'd3
  } fwd_e;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  localparam logic [1:0] TNEW_LINK = 2'd0;

  // One stage of aging, floored at zero.
  function automatic logic [1:0] tnew_dec(
    input logic [1:0] t
  );
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hzd_slot.sv
// One pipeline slot of producer/consumer info {we, wa, a1, a2, tnew}.
// Ports: clk_i, rst_ni (sync, active-low), bubble_i, dec_i, slot in/out.
module hzd_slot
  import hzd_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          bubble_i,
  input  logic          dec_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [AW-1:0] a1_i,
  input  logic [AW-1:0] a2_i,
  input  logic [1:0]    tnew_i,
  output logic          we_o,
  output logic [AW-1:0] wa_o,
  output logic [AW-1:0] a1_o,
  output logic [AW-1:0] a2_o,
  output logic [1:0]    tnew_o
);

  logic          we_q, we_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [AW-1:0] a1_q, a1_d;
  logic [AW-1:0] a2_q, a2_d;
  logic [1:0]    tnew_q, tnew_d;

  always_comb begin
    we_d   = we_i;
    wa_d   = wa_i;
    a1_d   = a1_i;
    a2_d   = a2_i;
    tnew_d = dec_i ? tnew_dec(tnew_i) : tnew_i;
    // A bubble clears every field so it can never match.
    if (bubble_i) begin
      we_d   = 1'b0;
      wa_d   = '0;
      a1_d   = '0;
      a2_d   = '0;
      tnew_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_q   <= 1'b0;
      wa_q   <= '0;
      a1_q   <= '0;
      a2_q   <= '0;
      tnew_q <= 2'd0;
    end else begin
      we_q   <= we_d;
      wa_q   <= wa_d;
      a1_q   <= a1_d;
      a2_q   <= a2_d;
      tnew_q <= tnew_d;
    end
  end

  assign we_o   = we_q;
  assign wa_o   = wa_q;
  assign a1_o   = a1_q;
  assign a2_o   = a2_q;
  assign tnew_o = tnew_q;

endmodule

// File: rtl/grf_hazard_ctrl.sv
// GRF hazard controller: tracks E/M/W producers, stalls D on Tuse/Tnew
// conflicts, drives D/E/M bypass selects and a saturating stall counter.
module grf_hazard_ctrl
  import hzd_pkg::*;
#(
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [AW-1:0]    D_A1,
  input  logic [AW-1:0]    D_A2,
  input  logic [1:0]       D_TUSE_RS,
  input  logic [1:0]       D_TUSE_RT,
  input  logic             D_WE,
  input  logic [AW-1:0]    D_WA,
  input  logic [1:0]       D_TNEW,
  output logic             STALL,
  output logic [1:0]       FWD_D_RS,
  output logic [1:0]       FWD_D_RT,
  output logic [1:0]       FWD_E_RS,
  output logic [1:0]       FWD_E_RT,
  output logic             FWD_M_RT,
  output logic [CNT_W-1:0] STALL_CNT
);

  logic          e_we, m_we;
  logic [AW-1:0] e_wa, m_wa;
  logic [AW-1:0] e_a1, m_a1;
  logic [AW-1:0] e_a2, m_a2;
  logic [1:0]    e_tnew, m_tnew;

  logic          w_we_q;
  logic [AW-1:0] w_wa_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  hzd_slot #(.AW(AW)) u_e (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .bubble_i (STALL),
    .dec_i    (1'b0),
    .we_i     (D_WE),
    .wa_i     (D_WA),
    .a1_i     (D_A1),
    .a2_i     (D_A2),
    .tnew_i   (D_TNEW),
    .we_o     (e_we),
    .wa_o     (e_wa),
    .a1_o     (e_a1),
    .a2_o     (e_a2),
    .tnew_o   (e_tnew)
  );

  hzd_slot #(.AW(AW)) u_m (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .bubble_i (1'b0),
    .dec_i    (1'b1),
    .we_i     (e_we),
    .wa_i     (e_wa),
    .a1_i     (e_a1),
    .a2_i     (e_a2),
    .tnew_i   (e_tnew),
    .we_o     (m_we),
    .wa_o     (m_wa),
    .a1_o     (m_a1),
    .a2_o     (m_a2),
    .tnew_o   (m_tnew)
  );

  // The store-data bypass only looks at M.a2.
  logic unused_m_a1;
  assign unused_m_a1 = ^m_a1;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      w_we_q <= 1'b0;
      w_wa_q <= '0;
    end else begin
      w_we_q <= m_we;
      w_wa_q <= m_wa;
    end
  end

  function automatic logic hit(
    input logic          we,
    input logic [AW-1:0] wa,
    input logic [AW-1:0] x
  );
    return we && (wa == x) && (x != '0);
  endfunction

  logic e_hit_rs, e_hit_rt;
  logic m_hit_rs, m_hit_rt;
  logic w_hit_rs, w_hit_rt;
  logic stall_rs, stall_rt;

  assign e_hit_rs = hit(e_we, e_wa, D_A1);
  assign e_hit_rt = hit(e_we, e_wa, D_A2);
  assign m_hit_rs = hit(m_we, m_wa, D_A1);
  assign m_hit_rt = hit(m_we, m_wa, D_A2);
  assign w_hit_rs = hit(w_we_q, w_wa_q, D_A1);
  assign w_hit_rt = hit(w_we_q, w_wa_q, D_A2);

  assign stall_rs = (e_hit_rs && (e_tnew > D_TUSE_RS))
                 || (m_hit_rs && (m_tnew > D_TUSE_RS));
  assign stall_rt = (e_hit_rt && (e_tnew > D_TUSE_RT))
                 || (m_hit_rt && (m_tnew > D_TUSE_RT));
  assign STALL    = stall_rs || stall_rt;

  // A younger hit that is not yet ready shadows older slots.
  function automatic logic [1:0] d_sel(
    input logic       eh,
    input logic [1:0] et,
    input logic       mh,
    input logic [1:0] mt,
    input logic       wh
  );
    logic [1:0] s;
    s = FWD_GRF;
    if (eh)      s = (et == 2'd0) ? FWD_E : FWD_GRF;
    else if (mh) s = (mt == 2'd0) ? FWD_M : FWD_GRF;
    else if (wh) s = FWD_W;
    return s;
  endfunction

  always_comb begin
    FWD_D_RS = d_sel(e_hit_rs, e_tnew,
                     m_hit_rs, m_tnew, w_hit_rs);
    FWD_D_RT = d_sel(e_hit_rt, e_tnew,
                     m_hit_rt, m_tnew, w_hit_rt);
    FWD_E_RS = d_sel(1'b0, 2'd0,
                     hit(m_we, m_wa, e_a1), m_tnew,
                     hit(w_we_q, w_wa_q, e_a1));
    FWD_E_RT = d_sel(1'b0, 2'd0,
                     hit(m_we, m_wa, e_a2), m_tnew,
                     hit(w_we_q, w_wa_q, e_a2));
    FWD_M_RT = hit(w_we_q, w_wa_q, m_a2);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (STALL && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign STALL_CNT = cnt_q;

endmodule
